// File: rtl/led_seq_pkg.sv
// Shared types for the LED pattern sequencer: FSM state encoding and table entry layout.
package led_seq_pkg;

  localparam int unsigned LedWidthDef   = 8;
  localparam int unsigned DwellWidthDef = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SHOW
  } state_e;

  // Layout of one table word; the RAM stores {pattern, dwell} in this order.
  typedef struct packed {
    logic [LedWidthDef-1:0]   pattern;
    logic [DwellWidthDef-1:0] dwell;
  } entry_t;

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Config, control and status signals of the LED pattern sequencer.
interface led_pattern_sequencer_if #(
  parameter int unsigned LED_WIDTH   = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned DWELL_WIDTH = 16
);
  localparam int unsigned AddrWidth = $clog2(DEPTH);

  logic                   cfg_wr_en;
  logic [AddrWidth-1:0]   cfg_wr_addr;
  logic [LED_WIDTH-1:0]   cfg_wr_pattern;
  logic [DWELL_WIDTH-1:0] cfg_wr_dwell;
  logic                   ctrl_start;
  logic                   ctrl_stop;
  logic                   ctrl_loop;
  logic [AddrWidth:0]     ctrl_length;
  logic [LED_WIDTH-1:0]   led_out;
  logic                   busy;
  logic                   done;
  logic [AddrWidth-1:0]   cur_index;

  modport master (
    output cfg_wr_en, cfg_wr_addr, cfg_wr_pattern, cfg_wr_dwell,
    output ctrl_start, ctrl_stop, ctrl_loop, ctrl_length,
    input  led_out, busy, done, cur_index
  );

  modport slave (
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_pattern, cfg_wr_dwell,
    input  ctrl_start, ctrl_stop, ctrl_loop, ctrl_length,
    output led_out, busy, done, cur_index
  );

endinterface

// File: rtl/led_seq_pattern_ram.sv
// Pattern table: simple dual-port RAM, one write port and one synchronous read-first read port.
module led_seq_pattern_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 24
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Non-blocking update gives old data on a same-edge read/write of one address.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps through a table of {pattern, dwell} entries, one-shot or looping, driving led_out.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned LED_WIDTH   = LedWidthDef,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned DWELL_WIDTH = DwellWidthDef,
  parameter int unsigned PRESCALE    = 100000
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  led_pattern_sequencer_if.slave bus
);

  localparam int unsigned AddrWidth  = $clog2(DEPTH);
  localparam int unsigned LenWidth   = AddrWidth + 1;
  localparam int unsigned PresWidth  = $clog2(PRESCALE + 1);
  localparam int unsigned EntryWidth = LED_WIDTH + DWELL_WIDTH;
  localparam logic [PresWidth-1:0] PresReload = PresWidth'(PRESCALE - 1);
  localparam logic [LenWidth-1:0]  DepthLen   = LenWidth'(DEPTH);

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   index_q, index_d;
  logic [AddrWidth-1:0]   cur_index_q, cur_index_d;
  logic [LenWidth-1:0]    len_q, len_d;
  logic                   loop_q, loop_d;
  logic                   done_q, done_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [PresWidth-1:0]   pres_q, pres_d;
  logic [LED_WIDTH-1:0]   led_q, led_d;

  logic                   rd_en;
  logic [EntryWidth-1:0]  rd_data;
  logic [LED_WIDTH-1:0]   rd_pattern;
  logic [DWELL_WIDTH-1:0] rd_dwell;
  logic                   last_entry;

  // Read is issued on the edge entering FETCH so the word is ready when FETCH ends.
  led_seq_pattern_ram #(
    .DEPTH(DEPTH),
    .WIDTH(EntryWidth)
  ) u_ram (
    .clk_i    (ACLK),
    .wr_en_i  (bus.cfg_wr_en),
    .wr_addr_i(bus.cfg_wr_addr),
    .wr_data_i({bus.cfg_wr_pattern, bus.cfg_wr_dwell}),
    .rd_en_i  (rd_en),
    .rd_addr_i(index_d),
    .rd_data_o(rd_data)
  );

  assign {rd_pattern, rd_dwell} = rd_data;
  assign last_entry = ({1'b0, index_q} == (len_q - LenWidth'(1)));

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    cur_index_d = cur_index_q;
    len_d       = len_q;
    loop_d      = loop_q;
    done_d      = 1'b0;
    dwell_d     = dwell_q;
    pres_d      = pres_q;
    led_d       = led_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.ctrl_start && !bus.ctrl_stop && (bus.ctrl_length != '0)) begin
          len_d   = (bus.ctrl_length > DepthLen) ? DepthLen : bus.ctrl_length;
          loop_d  = bus.ctrl_loop;
          index_d = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.ctrl_stop) begin
          state_d = S_IDLE;
        end else begin
          led_d       = rd_pattern;
          dwell_d     = rd_dwell;
          pres_d      = PresReload;
          cur_index_d = index_q;
          state_d     = S_SHOW;
        end
      end
      S_SHOW: begin
        if (bus.ctrl_stop) begin
          state_d = S_IDLE;
        end else if (pres_q != '0) begin
          pres_d = pres_q - PresWidth'(1);
        end else begin
          pres_d = PresReload;
          if (dwell_q != '0) begin
            dwell_d = dwell_q - DWELL_WIDTH'(1);
          end else if (!last_entry) begin
            index_d = index_q + AddrWidth'(1);
            state_d = S_FETCH;
          end else if (loop_q) begin
            index_d = '0;
            state_d = S_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    rd_en = (state_d == S_FETCH);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      index_q     <= '0;
      cur_index_q <= '0;
      len_q       <= '0;
      loop_q      <= 1'b0;
      done_q      <= 1'b0;
      dwell_q     <= '0;
      pres_q      <= '0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      cur_index_q <= cur_index_d;
      len_q       <= len_d;
      loop_q      <= loop_d;
      done_q      <= done_d;
      dwell_q     <= dwell_d;
      pres_q      <= pres_d;
      led_q       <= led_d;
    end
  end

  assign bus.led_out   = led_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.cur_index = cur_index_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: table of runs, per-cycle expected-output scoreboard.
module tb_led_pattern_sequencer;
  import led_seq_pkg::*;

  localparam int unsigned LW       = 8;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned DW       = 16;
  localparam int unsigned PRESCALE = 2;

  typedef struct packed {
    logic [7:0] led;
    logic       busy;
    logic       done;
    logic [1:0] cur;
  } exp_t;

  typedef struct {
    int         len;
    bit         lp;
    int         run;         // loop runs: busy cycles before stop is asserted
    int         restart_at;  // cycle to pulse start again (0 = never)
    int         wr_at;       // cycle to write the table (0 = never)
    int         wr_addr;
    logic [7:0] wr_pat;
    bit         wr_takes;    // write lands before the entry is fetched
    int         exp_busy;
    logic [7:0] exp_led;
    int         exp_done;
  } vec_t;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  led_pattern_sequencer_if #(.LED_WIDTH(LW), .DEPTH(DEPTH), .DWELL_WIDTH(DW)) bus ();

  led_pattern_sequencer #(
    .LED_WIDTH  (LW),
    .DEPTH      (DEPTH),
    .DWELL_WIDTH(DW),
    .PRESCALE   (PRESCALE)
  ) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .bus   (bus)
  );

  int         checks = 0;
  int         failures = 0;
  exp_t       q[$];
  entry_t     mdl [DEPTH];
  logic [7:0] prev_led = 8'h00;
  int         prev_cur = 0;
  vec_t       vecs [9];

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_exp(input string name, input exp_t got, input exp_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got led=%02h busy=%0b done=%0b cur=%0d expected led=%02h busy=%0b done=%0b cur=%0d",
               name, got.led, got.busy, got.done, got.cur, exp.led, exp.busy, exp.done, exp.cur);
    end
  endtask

  function automatic exp_t sample();
    exp_t g;
    g.led  = bus.led_out;
    g.busy = bus.busy;
    g.done = bus.done;
    g.cur  = bus.cur_index;
    return g;
  endfunction

  task automatic push(input logic [7:0] led, input logic b, input logic d, input int cur);
    exp_t e;
    e.led  = led;
    e.busy = b;
    e.done = d;
    e.cur  = 2'(cur);
    q.push_back(e);
  endtask

  // Expected per-cycle outputs from the cycle after start is sampled.
  task automatic gen_stream(input int len_in, input bit lp, input int run);
    int len, n, e;
    bit fin;
    len = (len_in > int'(DEPTH)) ? int'(DEPTH) : len_in;
    if (len == 0) begin
      repeat (3) push(prev_led, 1'b0, 1'b0, prev_cur);
      return;
    end
    push(prev_led, 1'b1, 1'b0, prev_cur);
    n = 1;
    e = 0;
    fin = 1'b0;
    while (!fin) begin
      for (int k = 0; k < int'(PRESCALE) * (int'(mdl[e].dwell) + 1) && !fin; k++) begin
        push(mdl[e].pattern, 1'b1, 1'b0, e);
        n++;
        fin = lp && (n == run);
      end
      prev_led = mdl[e].pattern;
      prev_cur = e;
      if (!fin) begin
        if (!lp && e == len - 1) begin
          push(prev_led, 1'b0, 1'b1, e);
          push(prev_led, 1'b0, 1'b0, e);
          return;
        end
        push(prev_led, 1'b1, 1'b0, e);
        n++;
        fin = lp && (n == run);
        e = (e == len - 1) ? 0 : e + 1;
      end
    end
    repeat (3) push(prev_led, 1'b0, 1'b0, prev_cur);
  endtask

  task automatic write_entry(input int addr, input logic [7:0] pat, input logic [15:0] dw);
    bus.cfg_wr_en      = 1'b1;
    bus.cfg_wr_addr    = 2'(addr);
    bus.cfg_wr_pattern = pat;
    bus.cfg_wr_dwell   = dw;
    @(posedge ACLK); #1;
    bus.cfg_wr_en = 1'b0;
    mdl[addr].pattern = pat;
    mdl[addr].dwell   = dw;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int   busy_cnt, done_cnt, i;
    exp_t e, g;
    busy_cnt = 0;
    done_cnt = 0;
    i = 0;
    if (v.wr_at != 0 && v.wr_takes) begin
      mdl[v.wr_addr].pattern = v.wr_pat;
      mdl[v.wr_addr].dwell   = '0;
    end
    gen_stream(v.len, v.lp, v.run);
    bus.ctrl_length = 3'(v.len);
    bus.ctrl_loop   = v.lp;
    bus.ctrl_start  = 1'b1;
    while (q.size() > 0) begin
      @(posedge ACLK); #1;
      i++;
      e = q.pop_front();
      g = sample();
      check_exp($sformatf("vec%0d_cyc%0d", id, i), g, e);
      if (g.busy) busy_cnt++;
      if (g.done) done_cnt++;
      bus.ctrl_start     = (v.restart_at == i);
      bus.ctrl_stop      = v.lp && (v.run == i);
      bus.cfg_wr_en      = (v.wr_at != 0) && (v.wr_at == i);
      bus.cfg_wr_addr    = 2'(v.wr_addr);
      bus.cfg_wr_pattern = v.wr_pat;
      bus.cfg_wr_dwell   = '0;
    end
    if (v.wr_at != 0 && !v.wr_takes) begin
      mdl[v.wr_addr].pattern = v.wr_pat;
      mdl[v.wr_addr].dwell   = '0;
    end
    check_int($sformatf("vec%0d_busy_cycles", id), busy_cnt, v.exp_busy);
    check_int($sformatf("vec%0d_done_pulses", id), done_cnt, v.exp_done);
    check_int($sformatf("vec%0d_final_led", id), int'(bus.led_out), int'(v.exp_led));
  endtask

  initial begin
    exp_t g, z;
    vec_t v;
    bus.cfg_wr_en      = 1'b0;
    bus.cfg_wr_addr    = '0;
    bus.cfg_wr_pattern = '0;
    bus.cfg_wr_dwell   = '0;
    bus.ctrl_start     = 1'b0;
    bus.ctrl_stop      = 1'b0;
    bus.ctrl_loop      = 1'b0;
    bus.ctrl_length    = '0;
    z = '0;

    //           len lp run rst wr adr pat    tk busy led    done
    vecs[0] = '{3, 1'b0, 0,  5, 0, 0, 8'h00, 1'b0, 11, 8'h04, 1};
    vecs[1] = '{1, 1'b0, 0,  0, 0, 0, 8'h00, 1'b0,  3, 8'h01, 1};
    vecs[2] = '{2, 1'b1, 14, 0, 0, 0, 8'h00, 1'b0, 14, 8'h02, 0};
    vecs[3] = '{7, 1'b0, 0,  0, 0, 0, 8'h00, 1'b0, 14, 8'h08, 1};
    vecs[4] = '{0, 1'b0, 0,  0, 0, 0, 8'h00, 1'b0,  0, 8'h08, 0};
    vecs[5] = '{7, 1'b1, 17, 0, 0, 0, 8'h00, 1'b0, 17, 8'h01, 0};
    vecs[6] = '{3, 1'b0, 0,  0, 2, 2, 8'hAA, 1'b1, 11, 8'hAA, 1};
    vecs[7] = '{3, 1'b0, 0,  0, 9, 2, 8'h55, 1'b0, 11, 8'hAA, 1};
    vecs[8] = '{3, 1'b0, 0,  0, 0, 0, 8'h00, 1'b0, 11, 8'h55, 1};

    repeat (5) @(posedge ACLK);
    #1;
    check_exp("reset_state", sample(), z);
    ARESET = 1'b0;

    write_entry(0, 8'h01, 16'd0);
    write_entry(1, 8'h02, 16'd1);
    write_entry(2, 8'h04, 16'd0);
    write_entry(3, 8'h08, 16'd0);
    check_exp("idle_after_writes", sample(), z);

    for (int r = 0; r < 9; r++) run_vec(r, vecs[r]);

    // Start and stop together in IDLE must not launch a run.
    bus.ctrl_length = 3'd3;
    bus.ctrl_loop   = 1'b0;
    bus.ctrl_start  = 1'b1;
    bus.ctrl_stop   = 1'b1;
    @(posedge ACLK); #1;
    bus.ctrl_start = 1'b0;
    bus.ctrl_stop  = 1'b0;
    check_int("start_stop_busy0", int'(bus.busy), 0);
    @(posedge ACLK); #1;
    check_int("start_stop_busy1", int'(bus.busy), 0);
    check_int("start_stop_led", int'(bus.led_out), 8'h55);

    // Reset in the middle of SHOW.
    bus.ctrl_start = 1'b1;
    @(posedge ACLK); #1;
    bus.ctrl_start = 1'b0;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    check_int("pre_reset_busy", int'(bus.busy), 1);
    check_int("pre_reset_led", int'(bus.led_out), 8'h01);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    g = sample();
    check_exp("mid_show_reset", g, z);
    prev_led = 8'h00;
    prev_cur = 0;
    v = vecs[8];
    run_vec(9, v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
